// File: rtl/conv_pkg.sv
// Shared definitions for the conv_max_pool slice: sample width default,
// signed minimum, pool FSM state encoding and the pooled output count helper.
package conv_pkg;

    localparam int data_width_default = 16;

    localparam logic signed [15:0] signed_min = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        DONE
    } pool_state_t;

    function automatic int pooled_output_count(input int rows, input int cols);
        return (rows / 2) * (cols / 2);
    endfunction

    localparam int default_pooled_outputs = pooled_output_count(218, 168);

endpackage

// File: rtl/conv_max_pool_if.sv
// Stream bundle between the convolution stage and the max-pooling stage.
// master drives the convolution stream, slave is the pooling block.
interface conv_max_pool_if
    import conv_pkg::*;
#(
    parameter int dataWidth = data_width_default
) ();

    logic signed [dataWidth-1:0] conv_data_in;
    logic                        conv_valid;
    logic                        conv_frame_done;
    logic signed [dataWidth-1:0] pool_data_out;
    logic                        pool_valid;
    logic                        pool_done;

    modport master (
        output conv_data_in,
        output conv_valid,
        output conv_frame_done,
        input  pool_data_out,
        input  pool_valid,
        input  pool_done
    );

    modport slave (
        input  conv_data_in,
        input  conv_valid,
        input  conv_frame_done,
        output pool_data_out,
        output pool_valid,
        output pool_done
    );

endinterface

// File: rtl/conv_max_pool_line_buffer.sv
// Half-width line buffer holding the horizontal pair maxima of the even row.
// Single port; reads and writes never coincide, read data is registered and
// holds its value until the next read.
module pool_line_buffer #(
    parameter int depth     = 84,
    parameter int dataWidth = 16,
    parameter int addrWidth = 7
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [addrWidth-1:0]        addr,
    input  logic signed [dataWidth-1:0] wr_data,
    output logic signed [dataWidth-1:0] rd_data
);

    logic signed [dataWidth-1:0] mem [0:depth-1];

    // Storage write and registered read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/conv_max_pool.sv
// Streaming 2x2 stride-2 max pooling of the signed convolution result stream.
// Even rows store horizontal pair maxima in a half-width line buffer; odd rows
// combine their own pair maxima with the stored ones and emit one value per
// window in raster order.
// Optional fused ReLU on the input samples: define CONV_MAX_POOL_RELU_EN.
module conv_max_pool
    import conv_pkg::*;
#(
    parameter int convRow            = 218,
    parameter int convColumn         = 168,
    parameter int dataWidth          = data_width_default,
    parameter int columnAddressWidth = 8,
    parameter int rowAddressWidth    = 8
) (
    input logic            clk,
    input logic            reset,
    conv_max_pool_if.slave bus
);

    localparam int lb_depth      = convColumn / 2;
    localparam int lb_addr_width = (lb_depth > 1) ? $clog2(lb_depth) : 1;

    localparam logic [columnAddressWidth-1:0] last_col_idx = columnAddressWidth'(convColumn - 1);
    localparam logic [columnAddressWidth-1:0] paired_cols  = columnAddressWidth'((convColumn / 2) * 2);
    localparam logic [rowAddressWidth-1:0]    last_row_idx = rowAddressWidth'(convRow - 1);

    pool_state_t                   state;
    pool_state_t                   state_next;
    logic [columnAddressWidth-1:0] col;
    logic [rowAddressWidth-1:0]    row;
    logic                          frame_done_q;

    logic signed [dataWidth-1:0]   sample;
    logic signed [dataWidth-1:0]   pair_hold;
    logic signed [dataWidth-1:0]   pair_max;
    logic signed [dataWidth-1:0]   lb_rd_data;
    logic signed [dataWidth-1:0]   pool_data_q;
    logic                          pool_valid_q;
    logic                          pool_done_q;

    logic take;
    logic odd_row;
    logic last_col;
    logic last_row;
    logic col_paired;
    logic enter_done;
    logic lb_wr_en;
    logic lb_rd_en;
    logic out_fire;

    // Input sample conditioning: optional clamp of negatives to zero.
    always_comb begin
`ifdef CONV_MAX_POOL_RELU_EN
        sample = bus.conv_data_in[dataWidth-1] ? '0 : bus.conv_data_in;
`else
        sample = bus.conv_data_in;
`endif
    end

    assign take       = bus.conv_valid && (state != DONE);
    assign odd_row    = (state == ODD_ROW);
    assign last_col   = (col == last_col_idx);
    assign last_row   = (row == last_row_idx);
    assign col_paired = (col < paired_cols);
    assign enter_done = bus.conv_frame_done && !frame_done_q && (state != DONE);

    assign pair_max = (sample > pair_hold) ? sample : pair_hold;
    assign lb_wr_en = take && !odd_row && col[0] && col_paired;
    assign lb_rd_en = take && odd_row && !col[0] && col_paired;
    assign out_fire = take && odd_row && col[0] && col_paired;

    // Row-parity FSM; a fresh frame_done edge overrides everything and
    // wrapping past the last row always restarts on an even row.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = EVEN_ROW;
                end
            end
            EVEN_ROW: begin
                if (take && last_col) begin
                    state_next = last_row ? EVEN_ROW : ODD_ROW;
                end
            end
            ODD_ROW: begin
                if (take && last_col) begin
                    state_next = EVEN_ROW;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (enter_done) begin
            state_next = DONE;
        end
    end

    // State register plus the frame_done history used to fire once per assertion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= bus.conv_frame_done;
        end
    end

    // Raster position of the next sample; cleared when a frame closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (enter_done || (state == DONE)) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Left sample of each horizontal pair waits here for its partner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_hold <= dataWidth'(signed_min);
        end else if (take && !col[0]) begin
            pair_hold <= sample;
        end
    end

    // Pooled result, its strobe and the end-of-frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pool_data_q  <= '0;
            pool_valid_q <= 1'b0;
            pool_done_q  <= 1'b0;
        end else begin
            pool_valid_q <= out_fire;
            pool_done_q  <= (state == DONE);
            if (out_fire) begin
                pool_data_q <= (pair_max > lb_rd_data) ? pair_max : lb_rd_data;
            end
        end
    end

    pool_line_buffer #(
        .depth     (lb_depth),
        .dataWidth (dataWidth),
        .addrWidth (lb_addr_width)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .rd_en   (lb_rd_en),
        .addr    (col[lb_addr_width:1]),
        .wr_data (pair_max),
        .rd_data (lb_rd_data)
    );

    assign bus.pool_data_out = pool_data_q;
    assign bus.pool_valid    = pool_valid_q;
    assign bus.pool_done     = pool_done_q;

endmodule

// File: tb/tb_conv_max_pool.sv
// Scoreboard bench for conv_max_pool: three instances (4x4, 5x5, 218x168)
// share clock and reset. The stimulus side pushes expected outputs and done
// pulses (with their due cycle) into per-instance queues; negedge monitors
// pop and compare whenever an instance strobes pool_valid or pool_done.
module tb_conv_max_pool;

    typedef struct {
        bit is_done;
        int value;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int   frame [0:36623];
    exp_t q4[$];
    exp_t q5[$];
    exp_t qd[$];

    conv_max_pool_if #(.dataWidth(16)) bus4 ();
    conv_max_pool_if #(.dataWidth(16)) bus5 ();
    conv_max_pool_if #(.dataWidth(16)) busd ();

    conv_max_pool #(.convRow(4), .convColumn(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    conv_max_pool #(.convRow(5), .convColumn(5)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    conv_max_pool dutd (
        .clk   (clk),
        .reset (reset),
        .bus   (busd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int relu(input int v);
`ifdef CONV_MAX_POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Maximum of the four (conditioned) samples of window (wr, wc).
    function automatic int window_max(input int cols, input int wr, input int wc);
        int m;
        int v;
        m = relu(frame[(2 * wr) * cols + 2 * wc]);
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = relu(frame[(2 * wr + dr) * cols + 2 * wc + dc]);
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    function automatic void push_exp(input int sel, input exp_t e);
        case (sel)
            0:       q4.push_back(e);
            1:       q5.push_back(e);
            default: qd.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int sel);
        case (sel)
            0:       return q4.size();
            1:       return q5.size();
            default: return qd.size();
        endcase
    endfunction

    function automatic bit pop_exp(input int sel, output exp_t e);
        e = '{is_done: 1'b0, value: 0, cyc: 0};
        if (q_size(sel) == 0) return 1'b0;
        case (sel)
            0:       e = q4.pop_front();
            1:       e = q5.pop_front();
            default: e = qd.pop_front();
        endcase
        return 1'b1;
    endfunction

    task automatic set_inputs(input int sel, input bit v, input int data, input bit fd);
        case (sel)
            0: begin
                bus4.conv_valid = v; bus4.conv_data_in = 16'(data); bus4.conv_frame_done = fd;
            end
            1: begin
                bus5.conv_valid = v; bus5.conv_data_in = 16'(data); bus5.conv_frame_done = fd;
            end
            default: begin
                busd.conv_valid = v; busd.conv_data_in = 16'(data); busd.conv_frame_done = fd;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor body: every strobe must match the head of that instance's queue.
    task automatic mon_step(input int sel, input bit v, input bit d, input int data);
        exp_t  e;
        bit    ok;
        string tag;
        tag = (sel == 0) ? "dut4x4" : (sel == 1) ? "dut5x5" : "dut218x168";
        if (v || d) begin
            check_output({tag, "_valid_done_exclusive"}, int'(v && d), 0);
        end
        if (v) begin
            ok = pop_exp(sel, e);
            check_output({tag, "_output_expected"}, int'(ok), 1);
            if (ok) begin
                check_output({tag, "_output_kind"}, int'(e.is_done), 0);
                check_output({tag, "_pool_value"}, data, e.value);
                check_output({tag, "_output_cycle"}, cyc, e.cyc);
            end
        end
        if (d) begin
            ok = pop_exp(sel, e);
            check_output({tag, "_done_expected"}, int'(ok), 1);
            if (ok) begin
                check_output({tag, "_done_kind"}, int'(e.is_done), 1);
                check_output({tag, "_done_cycle"}, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_step(0, bus4.pool_valid, bus4.pool_done, int'(bus4.pool_data_out));
            mon_step(1, bus5.pool_valid, bus5.pool_done, int'(bus5.pool_data_out));
            mon_step(2, busd.pool_valid, busd.pool_done, int'(busd.pool_data_out));
        end
    end

    task automatic fill_raster(input int n);
        for (int i = 0; i < n; i++) frame[i] = i;
    endtask

    task automatic fill_const(input int n, input int v);
        for (int i = 0; i < n; i++) frame[i] = v;
    endtask

    task automatic fill_random(input int n);
        logic signed [15:0] t;
        for (int i = 0; i < n; i++) begin
            t = 16'($urandom);
            if ($urandom_range(0, 15) == 0) t = 16'sh8000;
            else if ($urandom_range(0, 15) == 0) t = 16'sh7fff;
            frame[i] = int'(t);
        end
    endtask

    // Drives n_samples of frame[] in raster order. fd_hold > 0: frame_done
    // rides with the last sample for fd_hold cycles; 0: separate one-cycle
    // pulse after two idle cycles; < 0: no frame_done (aborted frame).
    task automatic apply_stimulus(input int sel, input int rows, input int cols,
                                  input int n_samples, input bit gaps, input int fd_hold);
        int r;
        int c;
        bit fd;
        for (int idx = 0; idx < n_samples; idx++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    set_inputs(sel, 1'b0, 0, 1'b0);
                    step();
                end
            end
            r  = idx / cols;
            c  = idx % cols;
            fd = (idx == n_samples - 1) && (fd_hold > 0);
            set_inputs(sel, 1'b1, frame[idx], fd);
            if ((r % 2 == 1) && (c % 2 == 1) && (r < (rows / 2) * 2) && (c < (cols / 2) * 2)) begin
                push_exp(sel, '{is_done: 1'b0, value: window_max(cols, r / 2, c / 2), cyc: cyc + 1});
            end
            if (fd) begin
                push_exp(sel, '{is_done: 1'b1, value: 0, cyc: cyc + 2});
            end
            step();
        end
        if (fd_hold > 0) begin
            set_inputs(sel, 1'b0, 0, 1'b1);
            repeat (fd_hold - 1) step();
            set_inputs(sel, 1'b0, 0, 1'b0);
        end else if (fd_hold == 0) begin
            set_inputs(sel, 1'b0, 0, 1'b0);
            step();
            step();
            set_inputs(sel, 1'b0, 0, 1'b1);
            push_exp(sel, '{is_done: 1'b1, value: 0, cyc: cyc + 2});
            step();
            set_inputs(sel, 1'b0, 0, 1'b0);
        end else begin
            set_inputs(sel, 1'b0, 0, 1'b0);
        end
    endtask

    // Bounded wait for all expectations of one instance to be consumed.
    task automatic wait_drain(input int sel, input int budget);
        int n;
        n = 0;
        while ((q_size(sel) != 0) && (n < budget)) begin
            step();
            n++;
        end
        check_output($sformatf("drain_sel%0d_pending", sel), q_size(sel), 0);
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: pending expectations %0d, expected 0", q4.size() + q5.size() + qd.size());
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 3; s++) set_inputs(s, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_pool_valid_4", int'(bus4.pool_valid), 0);
        check_output("reset_pool_done_4", int'(bus4.pool_done), 0);
        check_output("reset_pool_data_4", int'(bus4.pool_data_out), 0);
        check_output("reset_pool_valid_5", int'(bus5.pool_valid), 0);
        check_output("reset_pool_done_5", int'(bus5.pool_done), 0);
        check_output("reset_pool_data_5", int'(bus5.pool_data_out), 0);
        check_output("reset_pool_valid_d", int'(busd.pool_valid), 0);
        check_output("reset_pool_done_d", int'(busd.pool_done), 0);
        check_output("reset_pool_data_d", int'(busd.pool_data_out), 0);
        step();
        reset = 1'b0;
        step();

        $display("[TB] 4x4 raster 0..15");
        fill_raster(16);
        apply_stimulus(0, 4, 4, 16, 1'b0, 0);
        wait_drain(0, 50);

        $display("[TB] 4x4 constant -3 with gaps");
        fill_const(16, -3);
        apply_stimulus(0, 4, 4, 16, 1'b1, 0);
        wait_drain(0, 50);

        $display("[TB] 5x5 raster 0..24");
        fill_raster(25);
        apply_stimulus(1, 5, 5, 25, 1'b0, 0);
        wait_drain(1, 50);

        $display("[TB] 4x4 aborted by reset in the third row");
        fill_raster(16);
        apply_stimulus(0, 4, 4, 10, 1'b0, -1);
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check_output("midreset_pool_data", int'(bus4.pool_data_out), 0);
        check_output("midreset_pool_valid", int'(bus4.pool_valid), 0);
        check_output("midreset_pending", q_size(0), 0);
        step();
        reset = 1'b0;
        step();
        fill_random(16);
        apply_stimulus(0, 4, 4, 16, 1'b1, 0);
        wait_drain(0, 50);

        $display("[TB] 4x4 frame_done held 3 cycles with the last sample");
        fill_random(16);
        apply_stimulus(0, 4, 4, 16, 1'b1, 3);
        wait_drain(0, 50);

        $display("[TB] 5x5 random signed values");
        fill_random(25);
        apply_stimulus(1, 5, 5, 25, 1'b1, 0);
        wait_drain(1, 50);

        $display("[TB] 218x168 random frame with gaps");
        fill_random(218 * 168);
        apply_stimulus(2, 218, 168, 218 * 168, 1'b1, 0);
        wait_drain(2, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_max_pool.md
Name: conv_max_pool

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of single_convolution.
- Consumes the signed convolution result stream (write_data_output qualified by convDone_, frame end by fullConvDone_out).
- Emits one pooled value per 2x2 window in raster order, for the next layer or the output-file writer.
- Holds one half-width line buffer of horizontal pair maxima, so no full-frame storage is needed.

Parameters:
- convRow, 218, rows in the convolution output frame (imageRow-filterRow+1).
- convColumn, 168, columns in the convolution output frame (imageColumn-filterColumn+1).
- dataWidth, 16, sample width, two's complement.
- columnAddressWidth, 8, width of column counter and line-buffer address; must satisfy 2^columnAddressWidth >= convColumn.
- rowAddressWidth, 8, width of row counter; must satisfy 2^rowAddressWidth >= convRow.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- conv_data_in  input  dataWidth  signed convolution sample.
- conv_valid  input  1  conv_data_in valid this cycle (convDone_).
- conv_frame_done  input  1  convolution frame complete (fullConvDone_out).
- pool_data_out  output  dataWidth  signed pooled maximum.
- pool_valid  output  1  pool_data_out valid, one-cycle strobe.
- pool_done  output  1  one-cycle pulse after the last pooled output of a frame.

Behaviour:
- Reset values: pool_data_out=0, pool_valid=0, pool_done=0, counters=0, state=IDLE. Line-buffer contents are don't-care.
- Input contract: row-major order, one sample per conv_valid cycle, gaps allowed. There is no backpressure; the block accepts every valid sample.
- Counters: col (0..convColumn-1) and row (0..convRow-1). col wraps to 0 and row increments on the last column.
- States and transitions:
  - IDLE -> EVEN_ROW on the first conv_valid.
  - EVEN_ROW -> ODD_ROW at row end.
  - ODD_ROW -> EVEN_ROW at row end.
  - Any state -> DONE on conv_frame_done.
  - DONE -> IDLE after one cycle; pool_done=1 in DONE.
- Horizontal pairing: at even col, register the sample as pair_hold. At odd col, h = signed max(pair_hold, sample).
- EVEN_ROW, odd col: write h to line buffer address col>>1.
- ODD_ROW, even col: issue synchronous read of address col>>1.
- ODD_ROW, odd col: pool_data_out = signed max(h, line buffer read data); pool_valid=1 on the next clock edge.
- Latency: 1 cycle from the conv_valid carrying the bottom-right sample of a window to pool_valid.
- Ties: equal values give that value. All comparisons are signed.
- Odd convColumn: the last column of each row is dropped. Odd convRow: the last row is dropped (no writes used, no outputs).
- Outputs per frame: (convRow/2)*(convColumn/2), integer division. Default is 109*84 = 9156.
- conv_valid and conv_frame_done in the same cycle: the sample is processed first. The pooled output, if any, appears with pool_valid the next cycle, and pool_done follows one cycle after that.
- Early conv_frame_done (short frame): the partial window is discarded, pool_done pulses, and counters clear.
- conv_frame_done held high for several cycles: exactly one pool_done pulse. Rearm only after it deasserts.
- conv_valid while in DONE: ignored.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded, and the next frame starts at row 0, col 0.
- pool_valid and pool_done never assert in the same cycle.

Optional Feature:
- Macro: CONV_MAX_POOL_RELU_EN.
- Defined: each input sample is clamped to 0 if negative, before pairing (fused ReLU); pool_data_out is always >= 0.
- Undefined: raw signed samples are pooled, and negative outputs are possible.

Decomposition:
- Shared package conv_pkg holds:
  - dataWidth default;
  - signed minimum constant (16'sh8000);
  - pool state enum (IDLE, EVEN_ROW, ODD_ROW, DONE);
  - helper constant for pooled output count.
- Sub-module pool_line_buffer: single-port synchronous RAM, depth convColumn/2, width dataWidth, registered read, write-first not required (read and write never hit the same cycle).

Test Plan:
- 4x4 frame, values 0..15 raster -> outputs 5, 7, 13, 15; pool_valid one cycle after inputs 5, 7, 13, 15; pool_done once.
- 4x4 frame, all -3 -> four outputs of -3 (macro undefined); four outputs of 0 with CONV_MAX_POOL_RELU_EN.
- 5x5 frame (odd dimensions), values 0..24 -> outputs 6, 8, 16, 18 only; row 4 and col 4 ignored; then pool_done.
- Default 218x168 frame with random conv_valid gaps -> 9156 outputs matching a golden model; pool_done exactly once, after the last output.
- Reset asserted mid-row 3 of a 4x4 frame, then a full 4x4 frame -> no outputs from the aborted frame; the new frame gives the correct 4 outputs.
- conv_frame_done high for 3 cycles, coincident with the final sample -> last output, then a single pool_done the next cycle.
